fibonacci_bcd_converter: RTL
============================

# fibonacci_bcd_converter

Sequential binary-to-BCD converter that sits directly downstream of the Fibonacci generator. It takes the generator's 14-bit result and overflow flag when the generator pulses done, and converts the value to four BCD digits with a shift-add-3 (double-dabble) datapath, one bit per cycle. It holds the digits stable for the seven-segment display driver. The start/ready/done handshake matches the generator's, so the two blocks chain with no glue logic.

## Interface
- No parameters; widths are fixed: 14-bit binary in, 4 BCD digits out.
- clk_i  in  1  system clock; all state changes on the rising edge.
- reset_ni  in  1  asynchronous, active-low reset.
- start_i  in  1  conversion request; sampled only in IDLE. Connect to the generator's done_o.
- bin_i  in  14  unsigned binary value to convert. Connect to the generator's fibonacci_o.
- overflow_i  in  1  upstream overflow flag. Connect to the generator's overflow_o.
- ready_o  out  1  high in IDLE only (combinational from state).
- done_o  out  1  one-cycle pulse in DONE.
- overflow_o  out  1  registered; high when the held result is saturated.
- bcd3_o, bcd2_o, bcd1_o, bcd0_o  out  4 each  registered result digits, thousands down to units.

## Operation
- States:
  - IDLE: ready_o=1. On start_i, capture the request and branch:
    - If overflow_i=1 or bin_i>9999, go directly to DONE with a saturated result (digits 9,9,9,9 and overflow_next=1).
    - Otherwise load the shift register with bin_i, clear the 16-bit BCD working register, load bit counter=13, and go to OP.
  - OP: each cycle, every working digit ≥5 gets +3, then the combined {bcd,bin} register shifts left by 1.
    - If the counter is 0, write the working digits (as they are after this cycle's adjust/shift) into the output registers, set overflow_next=0, and go to DONE.
    - Otherwise decrement the counter.
  - DONE: done_o=1, then go to IDLE unconditionally.
  - Any illegal state encoding goes to IDLE.
- Output registers change only on the edge entering DONE; at all other times they hold the previous result.
- start_i outside IDLE is ignored; it is not queued.
- Arithmetic: the add-3 is applied per 4-bit digit with 4-bit wrap, and the correction is applied before the shift in the same cycle. The working register is 16 bits; with the ≤9999 check in place, no carry leaves digit 3.
- bin_i and overflow_i are sampled only on the accepting edge; later changes have no effect.

## Timing
- Reset (reset_ni=0, asynchronous): state=IDLE; digits 0,0,0,0; overflow_o=0; counter and working registers 0; ready_o=1; done_o=0.
- Normal conversion, with start accepted on edge T:
  - OP for T+1 through T+14 (14 cycles).
  - Outputs valid and done_o=1 during cycle T+15.
  - ready_o=1 again at T+16.
  - Latency from start to done is 15 cycles; throughput is one conversion per 16 cycles.
- Saturated path: done_o=1 during cycle T+1 and ready_o=1 at T+2; outputs update on edge T.
- ready_o=0 throughout OP and DONE. start_i held high continuously retriggers on every IDLE cycle.
- Reset asserted mid-OP or in DONE: the conversion aborts immediately, outputs clear to 0, and no done_o pulse occurs. The first start after reset release is accepted normally.
- Generator chaining: the generator's done_o and its data arrive in the same cycle. This block samples them on that edge while in IDLE, which requires ready_o=1 at that time.

## Test plan
- Reset values: hold reset_ni=0 for 3 cycles, release. Required: digits 0000, overflow_o=0, done_o=0, ready_o=1.
- Nominal conversion: bin_i=1597, overflow_i=0, start for 1 cycle at edge T. Required:
  - Digits 1,5,9,7 and done_o=1 exactly at T+15.
  - ready_o=0 for T+1..T+15.
  - Digits hold 1,5,9,7 after done.
- Boundaries:
  - bin_i=0 gives 0,0,0,0 with overflow_o=0.
  - bin_i=9999 gives 9,9,9,9 with overflow_o=0, both at 15 cycles.
  - bin_i=10000 gives 9,9,9,9 with overflow_o=1, done at T+1.
- Upstream overflow: overflow_i=1 with bin_i=233. Required: digits 9,9,9,9, overflow_o=1, done_o at T+1. The next conversion, bin_i=8, clears overflow_o and gives 0,0,0,8.
- Ignored start and input stability:
  - Convert 4181 and pulse start_i with bin_i=55 at T+5. Change bin_i freely during OP.
  - Required: result 4,1,8,1 at T+15, a single done pulse, and no second conversion.
- Reset mid-operation: start 6765, assert reset_ni=0 at T+7 for 2 cycles. Required: outputs 0 immediately, no done_o. A new start with 21 then gives 0,0,2,1 after 15 cycles.

Source files
------------

// File: rtl/fibonacci_bcd_converter.sv
// Sequential 14-bit binary to 4-digit BCD converter (shift-add-3, one bit per
// cycle). Chains directly behind the Fibonacci generator: start_i <- done_o,
// bin_i <- fibonacci_o, overflow_i <- overflow_o. Values above 9999 or an
// upstream overflow saturate to 9999 with overflow_o set.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | ready for a request; result registers hold last result
//   OP    | one adjust+shift per cycle, cnt_q counts 13 down to 0
//   DONE  | result valid, done_o pulses for this single cycle
module fibonacci_bcd_converter (
  input  logic        clk_i,
  input  logic        reset_ni,
  input  logic        start_i,
  input  logic [13:0] bin_i,
  input  logic        overflow_i,
  output logic        ready_o,
  output logic        done_o,
  output logic        overflow_o,
  output logic [3:0]  bcd3_o,
  output logic [3:0]  bcd2_o,
  output logic [3:0]  bcd1_o,
  output logic [3:0]  bcd0_o
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    OP   = 2'b01,
    DONE = 2'b10
  } state_e;

  state_e      state_q, state_d;
  logic [13:0] bin_q, bin_d;
  logic [15:0] bcd_q, bcd_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] res_q, res_d;
  logic        ovf_q, ovf_d;
  logic [15:0] adj;
  logic [29:0] shifted;

  // Per-digit add-3 correction (4-bit wrap), then the joint {bcd,bin} shift
  always_comb begin
    adj = bcd_q;
    for (int i = 0; i < 4; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) begin
        adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
    end
    shifted = {adj[14:0], bin_q, 1'b0};
  end

  // Next-state and datapath updates; result registers only move when entering DONE
  always_comb begin
    state_d = state_q;
    bin_d   = bin_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          if (overflow_i || (bin_i > 14'd9999)) begin
            res_d   = 16'h9999;
            ovf_d   = 1'b1;
            state_d = DONE;
          end else begin
            bin_d   = bin_i;
            bcd_d   = 16'h0000;
            cnt_d   = 4'd13;
            state_d = OP;
          end
        end
      end
      OP: begin
        bcd_d = shifted[29:14];
        bin_d = shifted[13:0];
        if (cnt_q == 4'd0) begin
          res_d   = shifted[29:14];
          ovf_d   = 1'b0;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers, cleared asynchronously
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q <= IDLE;
      bin_q   <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      res_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      ovf_q   <= ovf_d;
    end
  end

  assign ready_o    = (state_q == IDLE);
  assign done_o     = (state_q == DONE);
  assign overflow_o = ovf_q;
  assign bcd3_o     = res_q[15:12];
  assign bcd2_o     = res_q[11:8];
  assign bcd1_o     = res_q[7:4];
  assign bcd0_o     = res_q[3:0];

endmodule
